// File: rtl/rr_arb16_dec.sv
// 16-requester round-robin arbiter with a bounded hold time. The registered
// owner index drives a 4-to-16 decoder to form the one-hot grant vector.

module dec4to16 (
   input  logic [3:0]  w,
   input  logic        en,
   output logic [15:0] y
);

   always_comb begin
      y = '0;
      if (en) y[w] = 1'b1;
   end

endmodule

module rr_arb16_dec #(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CW       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic [3:0]  gnt_idx,
   output logic        gnt_vld,
   output logic        timeout
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state, state_n;
   logic [3:0]    idx_n;
   logic [3:0]    ptr, ptr_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          timeout_n;
   logic [3:0]    pick;

   // First requester at or after the pointer, wrapping modulo 16.
   function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
      logic [3:0] sel;
      logic [3:0] cand;
      logic       found;
      sel   = p;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cand = p + 4'(k);
         if (!found && r[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign pick = rr_pick(req, ptr);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_n   = state;
      idx_n     = gnt_idx;
      ptr_n     = ptr;
      cnt_n     = cnt;
      timeout_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req) begin
               idx_n   = pick;
               cnt_n   = CNT_ONE;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               ptr_n   = gnt_idx + 4'd1;
               state_n = IDLE;
            end else if (cnt == HOLD_LIM) begin
               ptr_n     = gnt_idx + 4'd1;
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt_idx <= '0;
         ptr     <= '0;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         state   <= state_n;
         gnt_idx <= idx_n;
         ptr     <= ptr_n;
         cnt     <= cnt_n;
         timeout <= timeout_n;
      end
   end

   // The IDLE cycle between owners gives the mandatory one-cycle dead time.
   assign gnt_vld = (state == GRANT);

   dec4to16 u_dec (
      .w  (gnt_idx),
      .en (gnt_vld),
      .y  (gnt)
   );

endmodule

// File: tb/tb_rr_arb16_dec.sv
// Directed bench for rr_arb16_dec: a vector table for single-edge behaviour
// plus hand-written sequences for timeouts, full rotation and async reset.

module tb_rr_arb16_dec;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_vld;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] req;
      logic [15:0] gnt;
      logic [3:0]  idx;
      logic        vld;
      logic        to;
   } vec_t;

   vec_t vecs[$];

   rr_arb16_dec #(.HOLD_MAX(8), .CW(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] e_gnt, input logic [3:0] e_idx,
                            input logic e_vld, input logic e_to);
      check({tag, ".gnt"}, gnt, e_gnt);
      check({tag, ".gnt_idx"}, 16'(gnt_idx), 16'(e_idx));
      check({tag, ".gnt_vld"}, 16'(gnt_vld), 16'(e_vld));
      check({tag, ".timeout"}, 16'(timeout), 16'(e_to));
   endtask

   // Drive req, let one rising edge sample it, look at the result on the falling edge.
   task automatic apply(input logic [15:0] r);
      req = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = '0;
      rst_n = 1'b0;
      #1;
      check_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add(input logic [15:0] r, input logic [15:0] g, input logic [3:0] i,
                      input logic v, input logic t);
      vec_t e;
      e.req = r; e.gnt = g; e.idx = i; e.vld = v; e.to = t;
      vecs.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;

      // Idle, single owner, pointer advance, 15->0 wrap, non-owner changes.
      for (int k = 0; k < 5; k++) add(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) add(16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0);
      add(16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0);
      add(16'h0003, 16'h0002, 4'd1,  1'b1, 1'b0);
      add(16'h0000, 16'h0000, 4'd1,  1'b0, 1'b0);
      add(16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0);
      add(16'h0000, 16'h0000, 4'd4,  1'b0, 1'b0);
      add(16'h8011, 16'h8000, 4'd15, 1'b1, 1'b0);
      add(16'h8011, 16'h8000, 4'd15, 1'b1, 1'b0);
      add(16'h0011, 16'h0000, 4'd15, 1'b0, 1'b0);
      add(16'h0011, 16'h0001, 4'd0,  1'b1, 1'b0);
      add(16'h0011, 16'h0001, 4'd0,  1'b1, 1'b0);
      add(16'h0010, 16'h0000, 4'd0,  1'b0, 1'b0);
      add(16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0);
      add(16'h0010, 16'h0010, 4'd4,  1'b1, 1'b0);
      add(16'h0000, 16'h0000, 4'd4,  1'b0, 1'b0);
      add(16'h0008, 16'h0008, 4'd3,  1'b1, 1'b0);
      add(16'h0088, 16'h0008, 4'd3,  1'b1, 1'b0);
      add(16'h008C, 16'h0008, 4'd3,  1'b1, 1'b0);
      add(16'h0084, 16'h0000, 4'd3,  1'b0, 1'b0);
      add(16'h0084, 16'h0080, 4'd7,  1'b1, 1'b0);
      add(16'h0004, 16'h0000, 4'd7,  1'b0, 1'b0);
      add(16'h0004, 16'h0004, 4'd2,  1'b1, 1'b0);
      add(16'h0000, 16'h0000, 4'd2,  1'b0, 1'b0);

      do_reset();
      for (int n = 0; n < vecs.size(); n++)
         begin
            apply(vecs[n].req);
            check_out($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].vld, vecs[n].to);
         end

      // Lone requester 5 (ptr=3): 8 granted cycles, timeout gap, re-grant, release.
      for (int k = 0; k < 8; k++) begin
         apply(16'h0020);
         check_out($sformatf("solo_hold%0d", k), 16'h0020, 4'd5, 1'b1, 1'b0);
      end
      apply(16'h0020);
      check_out("solo_revoke", 16'h0000, 4'd5, 1'b0, 1'b1);
      apply(16'h0020);
      check_out("solo_regrant", 16'h0020, 4'd5, 1'b1, 1'b0);
      apply(16'h0000);
      check_out("solo_release", 16'h0000, 4'd5, 1'b0, 1'b0);

      // All requesting: visit 0..15 then 0, each 8 cycles plus one timeout gap.
      do_reset();
      for (int o = 0; o < 17; o++) begin
         logic [3:0]  own;
         logic [15:0] oh;
         own = 4'(o);
         oh  = 16'h0001 << own;
         for (int k = 0; k < 8; k++) begin
            apply(16'hFFFF);
            check_out($sformatf("all_o%0d_c%0d", o, k), oh, own, 1'b1, 1'b0);
         end
         apply(16'hFFFF);
         check_out($sformatf("all_o%0d_gap", o), 16'h0000, own, 1'b0, 1'b1);
      end

      // Async reset mid-grant on owner 10, then search restarts from 0.
      do_reset();
      apply(16'h0400);
      check_out("pre_async", 16'h0400, 4'd10, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(16'h0000);
      check_out("post_reset_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
      apply(16'h8401);
      check_out("post_reset_grant", 16'h0001, 4'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arb16_dec.md
Name: rr_arb16_dec

Overview:
- 16-requester round-robin arbiter for one shared resource.
- The granted index is held in a register and drives an internal instance of the dec4to16 decoder (4-bit index plus enable). The decoder output is the one-hot grant vector.
- Sits between 16 request sources and the shared resource. The decoder enable doubles as the grant-valid strobe.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one requester may hold the grant. Legal range 1..255.
- CW, 8: width of the hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit i is held high by requester i while it wants the resource.
- gnt  output  16  one-hot grant, equal to dec4to16(w=gnt_idx, en=gnt_vld); all zeros when gnt_vld=0.
- gnt_idx  output  4  encoded index of the current owner; holds the last owner when idle.
- gnt_vld  output  1  a grant is active; drives the decoder enable.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked at HOLD_MAX.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt_vld=0, gnt_idx=0, gnt=16'h0000, timeout=0.
  - Round-robin pointer ptr=0; hold counter cnt=0.
  - Takes effect immediately, even mid-grant. No grant is issued in the first edge after release of reset unless req is already sampled high on that edge.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, ..., ptr+15, wrapping modulo 16.
  - On the same edge: gnt_idx<=i, gnt_vld<=1, cnt<=1, state<=GRANT.
  - Grant latency is 1 cycle from the edge that samples req.
- State GRANT, checked in priority order on each edge:
  - a) req[gnt_idx]=0 (owner released): gnt_vld<=0, ptr<=gnt_idx+1 (mod 16), state<=IDLE, timeout<=0.
  - b) cnt==HOLD_MAX with req[gnt_idx]=1: gnt_vld<=0, ptr<=gnt_idx+1, timeout<=1 for exactly one cycle, state<=IDLE.
  - c) otherwise: cnt<=cnt+1, grant held unchanged.
- Dead cycle: every grant hand-off includes exactly one cycle with gnt=0 (the IDLE cycle). Grants of two owners never overlap or abut.
- Grant duration: maximum is HOLD_MAX cycles with gnt_vld=1.
- Request changes during a grant:
  - Changes on non-owner bits have no effect.
  - An owner that drops and re-asserts req in the same cycle it is sampled is treated as a release, because sampling is by edge only.
- Pointer wrap: owner 15 releases -> ptr=0.
- Single requester: a requester that stays asserted alone is re-granted after every timeout, with one dead cycle between grants.
- gnt is purely combinational from registered gnt_idx/gnt_vld through the decoder. It is glitch-free relative to clk and is never multi-hot.
- timeout is registered. It is 0 in every cycle except the one immediately following a forced revoke.

Test Plan:
- Reset then req=16'h0000 for 5 cycles -> gnt=0, gnt_vld=0, gnt_idx=0, timeout=0 throughout.
- req=16'h0001, hold 3 cycles, drop -> gnt=16'h0001 one cycle after assertion. Gnt drops the edge after req falls; ptr=1.
- req=16'hFFFF continuously, HOLD_MAX=8:
  - grants visit 0,1,2,...,15,0 in order;
  - each lasts 8 cycles, followed by a 1-cycle gap;
  - timeout pulses once per grant.
- ptr=5 (after owner 4 releases), then req=16'h8011 -> grant order 15, 0, 4, each requester dropping req after 2 cycles.
- Owner 3 holding; assert req[7] and req[2] mid-grant -> no change until owner 3 releases. Next grant is 7 (search from 4), then 2.
- Assert rst_n=0 asynchronously mid-grant (gnt=16'h0400) -> gnt, gnt_vld and timeout go to 0 immediately without a clock edge. After release, the first grant searches from ptr=0.
